multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle MIPS main controller. It replaces the single-cycle opcode decoder with a Moore-style FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It adds memory wait-state handling, optional extended opcodes, illegal-opcode detection and a retired-instruction counter. It sits beside the ALU decoder and drives the shared-memory multicycle datapath.

## Interface

- EXT_OPS, 1, when 1 the block decodes bne/andi/ori; when 0 those opcodes are illegal.
- MEM_HS, 1, when 1 memory states wait on mem_ready; when 0 mem_ready is treated as constant 1.
- CNT_W, 32, width of the retired-instruction counter.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- memreq, memwrite, iord  out  1 each  memory request, memory write, and address select (1 = ALUOut).
- irwrite, pcwrite  out  1 each  IR load and unconditional PC load.
- branch, branch_ne  out  1 each  PC load on zero / on not-zero.
- regwrite, regdst, memtoreg  out  1 each  register-file controls.
- alusrca  out  1  ALU A source (0 = PC, 1 = rs).
- alusrcb  out  2  ALU B source: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- zeroext  out  1  immediate is zero-extended.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- aluop  out  3  000 = add, 001 = sub, 010 = funct, 011 = and, 100 = or.
- illegal_op  out  1  one-cycle pulse when an undecodable opcode is seen.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

## Operation

- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12–15 are unused and go to FETCH.
- Any output not listed for a state is 0.
- FETCH: memreq=1, alusrcb=01, aluop=000. irwrite and pcwrite equal mem_ready (combinational). The FSM stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrcb=11, aluop=000. Next state by op:
  - 000000 → EXECUTE.
  - 100011 or 101011 → MEMADR.
  - 000100 → BRANCH.
  - 001000 → IEXEC.
  - 000010 → JUMP.
  - 000101, 001100, 001101 → BRANCH or IEXEC when EXT_OPS=1.
  - Anything else: illegal_op=1 this cycle, next state FETCH.
- The opcode is latched in DECODE into an internal register op_q. All later states use op_q; op may change after DECODE.
- MEMADR: alusrca=1, alusrcb=10. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: memreq=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Next is FETCH.
- MEMWRITE: memreq=1, memwrite=1, iord=1. memwrite stays high for the whole wait. On mem_ready, go to FETCH.
- EXECUTE: alusrca=1, aluop=010. Next is ALUWB.
- ALUWB: regdst=1, regwrite=1. Next is FETCH.
- BRANCH: alusrca=1, aluop=001, pcsrc=01. branch=1 for beq, branch_ne=1 for bne. Next is FETCH.
- IEXEC: alusrca=1, alusrcb=10. aluop is 000 (addi), 011 (andi) or 100 (ori). zeroext=1 for andi and ori. Next is IWB.
- IWB: regwrite=1, regdst=0. Next is FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next is FETCH.
- Retired counter:
  - Increments by 1 in the cycle after an instruction's final cycle completes. Final cycles are MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH, IWB and JUMP.
  - Illegal opcodes are not counted.
  - The counter wraps modulo 2^CNT_W.

## Timing

- Reset:
  - State goes to FETCH, op_q to 0, retired to 0.
  - While reset is high, every enable is forced to 0: memreq, memwrite, irwrite, pcwrite, branch, branch_ne, regwrite, illegal_op.
  - The first fetch request is issued in the cycle after reset deasserts.
- Reset asserted mid-instruction (including during a memory wait) aborts the instruction. No write enable asserts in the reset cycle, and the aborted instruction is not counted.
- Latency with zero wait states:
  - 3 cycles: beq, bne, j.
  - 4 cycles: R-type, addi, andi, ori, sw.
  - 5 cycles: lw.
- Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- A mem_ready pulse coincident with reset is ignored.

## Test plan

- Reset held 2 cycles, then released with mem_ready=1 → state=0 and all enables 0 during reset; memreq=1 in the first cycle after release; retired=0.
- Sequence lw, sw, R-type, addi, beq, j with mem_ready=1 → state traces match the cycle counts 5/4/4/4/3/3; retired=6 after 23 cycles. In the lw writeback cycle: memtoreg=1, regwrite=1, regdst=0.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMREAD → total 10 cycles. irwrite pulses exactly once; memreq is continuous across each wait.
- EXT_OPS=1: bne gives branch_ne=1, aluop=001; andi gives aluop=011, zeroext=1. EXT_OPS=0: the same opcodes give illegal_op=1 in DECODE, return to FETCH, and retired is unchanged.
- Reset asserted during a MEMWRITE wait → memwrite=0 in the reset cycle; state=FETCH after release; retired unchanged.
- With CNT_W=4, retire 17 instructions → retired=1 (wrap).

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/exec/mem/wb,
// with memory wait states, optional bne/andi/ori, illegal-op pulse and retire count.
module multicycle_ctrl #(
  parameter bit EXT_OPS = 1'b1,
  parameter bit MEM_HS  = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             memreq,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [1:0]       pcsrc,
  output logic [2:0]       aluop,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] retired_q;

  logic rdy, done;
  logic memreq_c, memwrite_c, irwrite_c, pcwrite_c;
  logic branch_c, branch_ne_c, regwrite_c, illegal_c;

  assign rdy = mem_ready | ~MEM_HS;

  always_comb begin
    state_d     = state_q;
    done        = 1'b0;
    memreq_c    = 1'b0;
    memwrite_c  = 1'b0;
    irwrite_c   = 1'b0;
    pcwrite_c   = 1'b0;
    branch_c    = 1'b0;
    branch_ne_c = 1'b0;
    regwrite_c  = 1'b0;
    illegal_c   = 1'b0;
    iord        = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    zeroext     = 1'b0;
    pcsrc       = 2'b00;
    aluop       = 3'b000;
    case (state_q)
      S_FETCH: begin
        memreq_c  = 1'b1;
        alusrcb   = 2'b01;
        irwrite_c = rdy;
        pcwrite_c = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        state_d = S_FETCH;
        case (op)
          OP_R:         state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_IEXEC;
          OP_J:         state_d = S_JUMP;
          OP_BNE: begin
            if (EXT_OPS) state_d = S_BRANCH;
            else         illegal_c = 1'b1;
          end
          OP_ANDI, OP_ORI: begin
            if (EXT_OPS) state_d = S_IEXEC;
            else         illegal_c = 1'b1;
          end
          default: illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memreq_c = 1'b1;
        iord     = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        memreq_c   = 1'b1;
        memwrite_c = 1'b1;
        iord       = 1'b1;
        if (rdy) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 3'b001;
        pcsrc       = 2'b01;
        branch_c    = (op_q == OP_BEQ);
        branch_ne_c = (op_q == OP_BNE);
        done        = 1'b1;
        state_d     = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op_q == OP_ANDI)     aluop = 3'b011;
        else if (op_q == OP_ORI) aluop = 3'b100;
        zeroext = (op_q == OP_ANDI) || (op_q == OP_ORI);
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite_c = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset is synchronous, so enables are masked directly to kill any in-flight write.
  assign memreq     = memreq_c    & ~reset;
  assign memwrite   = memwrite_c  & ~reset;
  assign irwrite    = irwrite_c   & ~reset;
  assign pcwrite    = pcwrite_c   & ~reset;
  assign branch     = branch_c    & ~reset;
  assign branch_ne  = branch_ne_c & ~reset;
  assign regwrite   = regwrite_c  & ~reset;
  assign illegal_op = illegal_c   & ~reset;
  assign state      = state_q;
  assign retired    = retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= op;
      if (done) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: three instances cover EXT_OPS=1,
// EXT_OPS=0 and a 4-bit retire counter, all driven by one shared stimulus.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mem_ready;
  logic [5:0] op;

  logic [2:0] memreq, memwrite, iord, irwrite, pcwrite;
  logic [2:0] branch, branch_ne, regwrite, regdst, memtoreg;
  logic [2:0] alusrca, zeroext, illegal_op;
  logic [2:0][1:0] alusrcb, pcsrc;
  logic [2:0][2:0] aluop;
  logic [2:0][3:0] st;
  logic [31:0] ret0, ret1;
  logic [3:0]  ret2;

  int ncmp = 0;
  int nerr = 0;
  int ir_cnt = 0;

  multicycle_ctrl #(.EXT_OPS(1'b1), .MEM_HS(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .memreq(memreq[0]), .memwrite(memwrite[0]), .iord(iord[0]),
    .irwrite(irwrite[0]), .pcwrite(pcwrite[0]), .branch(branch[0]),
    .branch_ne(branch_ne[0]), .regwrite(regwrite[0]), .regdst(regdst[0]),
    .memtoreg(memtoreg[0]), .alusrca(alusrca[0]), .alusrcb(alusrcb[0]),
    .zeroext(zeroext[0]), .pcsrc(pcsrc[0]), .aluop(aluop[0]),
    .illegal_op(illegal_op[0]), .state(st[0]), .retired(ret0)
  );

  multicycle_ctrl #(.EXT_OPS(1'b0), .MEM_HS(1'b1), .CNT_W(32)) dut_x0 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .memreq(memreq[1]), .memwrite(memwrite[1]), .iord(iord[1]),
    .irwrite(irwrite[1]), .pcwrite(pcwrite[1]), .branch(branch[1]),
    .branch_ne(branch_ne[1]), .regwrite(regwrite[1]), .regdst(regdst[1]),
    .memtoreg(memtoreg[1]), .alusrca(alusrca[1]), .alusrcb(alusrcb[1]),
    .zeroext(zeroext[1]), .pcsrc(pcsrc[1]), .aluop(aluop[1]),
    .illegal_op(illegal_op[1]), .state(st[1]), .retired(ret1)
  );

  multicycle_ctrl #(.EXT_OPS(1'b1), .MEM_HS(1'b1), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .memreq(memreq[2]), .memwrite(memwrite[2]), .iord(iord[2]),
    .irwrite(irwrite[2]), .pcwrite(pcwrite[2]), .branch(branch[2]),
    .branch_ne(branch_ne[2]), .regwrite(regwrite[2]), .regdst(regdst[2]),
    .memtoreg(memtoreg[2]), .alusrca(alusrca[2]), .alusrcb(alusrcb[2]),
    .zeroext(zeroext[2]), .pcsrc(pcsrc[2]), .aluop(aluop[2]),
    .illegal_op(illegal_op[2]), .state(st[2]), .retired(ret2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // seq: one hex digit per cycle (first cycle leftmost); rdy: one bit per cycle.
  task automatic run(input logic [5:0] o, input int n,
                     input logic [39:0] seq, input logic [9:0] rdy);
    op = o;
    for (int i = 0; i < n; i++) begin
      logic [3:0] s;
      s = seq[4*(n-1-i) +: 4];
      mem_ready = rdy[n-1-i];
      #2;
      chk($sformatf("state_op%0h_c%0d", o, i), 32'(st[0]), 32'(s));
      if (s == 4'd0 && irwrite[0]) ir_cnt++;
      if (s == 4'd0 || s == 4'd3 || s == 4'd5)
        chk("memreq_held", 32'(memreq[0]), 32'd1);
      if (s == 4'd4) begin
        chk("lw_wb_memtoreg", 32'(memtoreg[0]), 32'd1);
        chk("lw_wb_regwrite", 32'(regwrite[0]), 32'd1);
        chk("lw_wb_regdst", 32'(regdst[0]), 32'd0);
      end
      if (s == 4'd11) begin
        chk("j_pcwrite", 32'(pcwrite[0]), 32'd1);
        chk("j_pcsrc", 32'(pcsrc[0]), 32'd2);
      end
      cyc;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    op = OP_R;
    cyc;
    #2;
    chk("rst_state", 32'(st[0]), 32'd0);
    chk("rst_memreq", 32'(memreq[0]), 32'd0);
    chk("rst_irwrite", 32'(irwrite[0]), 32'd0);
    chk("rst_pcwrite", 32'(pcwrite[0]), 32'd0);
    chk("rst_retired", ret0, 32'd0);
    cyc;
    reset = 1'b0;
    #1;
    chk("first_fetch_memreq", 32'(memreq[0]), 32'd1);
    chk("first_retired", ret0, 32'd0);

    run(OP_LW,   5, 40'h01234, 10'h3ff);
    run(OP_SW,   4, 40'h0125,  10'h3ff);
    run(OP_R,    4, 40'h0167,  10'h3ff);
    run(OP_ADDI, 4, 40'h019a,  10'h3ff);
    run(OP_BEQ,  3, 40'h018,   10'h3ff);
    run(OP_J,    3, 40'h01b,   10'h3ff);
    #2;
    chk("ret_after_seq", ret0, 32'd6);
    chk("ret_after_seq_x0", ret1, 32'd6);
    chk("ret_after_seq_c4", 32'(ret2), 32'd6);

    ir_cnt = 0;
    run(OP_LW, 10, 40'h0000123334, 10'b0001110011);
    #2;
    chk("lw_wait_irwrite_once", 32'(ir_cnt), 32'd1);
    chk("ret_after_lw_wait", ret0, 32'd7);

    mem_ready = 1'b1;
    op = OP_BNE;
    #2;
    chk("bne_fetch", 32'(st[0]), 32'd0);
    chk("bne_fetch_x0", 32'(st[1]), 32'd0);
    cyc;
    #2;
    chk("bne_decode", 32'(st[0]), 32'd1);
    chk("bne_ill_ext1", 32'(illegal_op[0]), 32'd0);
    chk("bne_ill_ext0", 32'(illegal_op[1]), 32'd1);
    cyc;
    #2;
    chk("bne_branch_state", 32'(st[0]), 32'd8);
    chk("bne_branch_ne", 32'(branch_ne[0]), 32'd1);
    chk("bne_branch", 32'(branch[0]), 32'd0);
    chk("bne_aluop", 32'(aluop[0]), 32'd1);
    chk("bne_x0_back_fetch", 32'(st[1]), 32'd0);
    chk("bne_x0_ill_gone", 32'(illegal_op[1]), 32'd0);
    cyc;
    #2;
    chk("bne_retired", ret0, 32'd8);
    chk("bne_retired_x0", ret1, 32'd7);
    chk("bne_retired_c4", 32'(ret2), 32'd8);

    reset = 1'b1;
    cyc;
    reset = 1'b0;
    op = OP_ANDI;
    #2;
    chk("andi_fetch", 32'(st[0]), 32'd0);
    chk("andi_ret_cleared", ret0, 32'd0);
    cyc;
    #2;
    chk("andi_decode", 32'(st[0]), 32'd1);
    chk("andi_ill_ext0", 32'(illegal_op[1]), 32'd1);
    cyc;
    #2;
    chk("andi_iexec", 32'(st[0]), 32'd9);
    chk("andi_aluop", 32'(aluop[0]), 32'd3);
    chk("andi_zeroext", 32'(zeroext[0]), 32'd1);
    chk("andi_alusrcb", 32'(alusrcb[0]), 32'd2);
    chk("andi_x0_fetch", 32'(st[1]), 32'd0);
    cyc;
    #2;
    chk("andi_iwb", 32'(st[0]), 32'd10);
    chk("andi_iwb_regwrite", 32'(regwrite[0]), 32'd1);
    chk("andi_iwb_regdst", 32'(regdst[0]), 32'd0);
    cyc;
    #2;
    chk("andi_retired", ret0, 32'd1);
    chk("andi_retired_x0", ret1, 32'd0);

    reset = 1'b1;
    cyc;
    reset = 1'b0;
    op = OP_SW;
    mem_ready = 1'b1;
    #2;
    chk("swr_fetch", 32'(st[0]), 32'd0);
    cyc;
    cyc;
    cyc;
    mem_ready = 1'b0;
    #2;
    chk("swr_memwrite", 32'(st[0]), 32'd5);
    chk("swr_memwrite_hi", 32'(memwrite[0]), 32'd1);
    cyc;
    #2;
    chk("swr_wait_memwrite_hi", 32'(memwrite[0]), 32'd1);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("swr_rst_memwrite", 32'(memwrite[0]), 32'd0);
    chk("swr_rst_memreq", 32'(memreq[0]), 32'd0);
    cyc;
    reset = 1'b0;
    #2;
    chk("swr_after_state", 32'(st[0]), 32'd0);
    chk("swr_after_retired", ret0, 32'd0);
    chk("swr_after_memreq", 32'(memreq[0]), 32'd1);

    for (int k = 0; k < 17; k++) run(OP_J, 3, 40'h01b, 10'h3ff);
    #2;
    chk("wrap_ret32", ret0, 32'd17);
    chk("wrap_ret4", 32'(ret2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
